// File: rtl/pipe_delay_line.sv
`default_nettype none
// pipe_delay_line: elastic DEPTH-stage registered delay line with valid/ready
// handshake, bubble collapse, synchronous flush and registered occupancy.
// Revision: 1.0
module pipe_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CW-1:0]    occupancy
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_occ;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic [DEPTH-1:0] w_valid_nxt;
  logic [DEPTH-1:0] w_load;
  logic [CW-1:0]    w_occ_nxt;

  // ready_k = !valid_k | ready_{k+1} unrolled: a stage may advance when the
  // consumer is ready or any stage from k to the tail is empty.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      assign w_ready[k] = out_ready | ~(&r_valid[DEPTH-1:k]);

      if (k == 0) begin : g_head
        assign w_src_valid[k] = in_valid;
        assign w_src_data[k]  = in_data;
      end else begin : g_body
        assign w_src_valid[k] = r_valid[k-1];
        assign w_src_data[k]  = r_data[k-1];
      end

      assign w_valid_nxt[k] = flush ? 1'b0 :
                              (w_ready[k] ? w_src_valid[k] : r_valid[k]);
      assign w_load[k]      = !flush && w_ready[k] && w_src_valid[k];
    end
  endgenerate

  always_comb begin
    w_occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ_nxt = w_occ_nxt + CW'(w_valid_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
      // Data only moves with a valid word; bubbles and flushes leave it as is.
      for (int k = 0; k < DEPTH; k++) begin
        if (w_load[k]) begin
          r_data[k] <= w_src_data[k];
        end
      end
    end
  end

  assign in_ready  = w_ready[0] & ~flush;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_delay_line.sv
`default_nettype none
// tb_pipe_delay_line: scoreboard bench for pipe_delay_line at (8,4), (32,1), (1,7).
module tb_pipe_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0] in_data, out_data;
  logic [2:0] occupancy;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [0:0]  a_occupancy;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [0:0] b_in_data, b_out_data;
  logic [2:0] b_occupancy;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  pipe_delay_line #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .occupancy(occupancy));

  pipe_delay_line #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready), .flush(a_flush),
    .occupancy(a_occupancy));

  pipe_delay_line #(.WIDTH(1), .DEPTH(7)) u_d7 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready), .flush(b_flush),
    .occupancy(b_occupancy));

  // One clock of the main DUT: inputs are already set at the falling edge.
  task automatic cycle();
    logic       acc, emit;
    logic [7:0] exp;
    #1;
    acc  = in_valid & in_ready;
    emit = out_valid & out_ready;
    if (emit) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_order: got out_data=%h, required no output (scoreboard empty)", out_data);
      end else begin
        exp = sb.pop_front();
        if (out_data !== exp) begin
          failures++;
          $display("FAIL sb_order: got out_data=%h, required %h", out_data, exp);
        end
      end
    end
    if (acc) sb.push_back(in_data);
    if (flush) sb.delete();
    @(posedge clk);
    #1;
    checks++;
    if (int'(occupancy) !== sb.size()) begin
      failures++;
      $display("FAIL occupancy: got %0d, required %0d", occupancy, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h occ=%0d rdy=%b, required 0 00 0 1",
               out_valid, out_data, occupancy, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      in_data = 8'(n);
      cycle();
      checks++;
      if (out_valid !== (n >= 4)) begin
        failures++;
        $display("FAIL stream_valid: edge %0d got out_valid=%b, required %b", n, out_valid, n >= 4);
      end
      if (n >= 4) begin
        checks++;
        if (out_data !== 8'(n - 3)) begin
          failures++;
          $display("FAIL stream_data: edge %0d got %h, required %h", n, out_data, 8'(n - 3));
        end
      end
    end
    drain(5);
  endtask

  task automatic test_backpressure();
    int   idx;
    logic took;
    idx = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      in_data = 8'hA0 + 8'(idx);
      #1;
      checks++;
      if (in_ready !== (c <= 4)) begin
        failures++;
        $display("FAIL bp_in_ready: cycle %0d got %b, required %b", c, in_ready, c <= 4);
      end
      took = in_ready;
      cycle();
      if (took) idx++;
    end
    checks++;
    if (occupancy !== 3'd4) begin
      failures++;
      $display("FAIL bp_full_occ: got %0d, required 4", occupancy);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      in_valid = (idx < 6);
      in_data  = 8'hA0 + 8'(idx);
      #1;
      if (r == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL full_passthru_ready: got in_ready=%b, required 1", in_ready);
        end
      end
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_no_gap: release cycle %0d got out_valid=%b, required 1", r, out_valid);
      end
      took = in_valid & in_ready;
      cycle();
      if (took) idx++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained: got left=%0d out_valid=%b, required 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_bubble();
    logic [7:0] dat [6] = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00};
    logic [5:0] vld = 6'b001001;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = vld[c];
      in_data  = dat[c];
      cycle();
    end
    checks++;
    if (occupancy !== 3'd2 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      failures++;
      $display("FAIL bubble_hold: got occ=%0d v=%b d=%h, required 2 1 11", occupancy, out_valid, out_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bubble_consec: cycle %0d got out_valid=%b, required 1", c, out_valid);
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bubble_empty: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic wait_latency(input string name, input logic [7:0] word);
    int n;
    n = 1;
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 4 || out_data !== word) begin
      failures++;
      $display("FAIL %s: got edges=%0d data=%h, required 4 %h", name, n, out_data, word);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h31 + 8'(i);
      cycle();
    end
    flush   = 1'b1;
    in_data = 8'h55;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready: got %b, required 0", in_ready);
    end
    cycle();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      failures++;
      $display("FAIL flush_clear: got v=%b occ=%0d, required 0 0", out_valid, occupancy);
    end
    in_data = 8'h66;
    cycle();
    wait_latency("flush_latency", 8'h66);
    drain(3);
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC0 + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 3'd0) begin
      failures++;
      $display("FAIL midstream_reset: got v=%b d=%h occ=%0d, required 0 00 0",
               out_valid, out_data, occupancy);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    cycle();
    wait_latency("reset_latency", 8'h77);
    drain(3);
  endtask

  task automatic test_sweep_d1();
    logic [31:0] q[$];
    logic [31:0] e;
    logic        acc, emit, pend;
    pend = 1'b0;
    for (int c = 0; c < 340; c++) begin
      if (!pend) begin
        a_in_valid = (c < 300) && ($urandom_range(0, 1) == 1);
        a_in_data  = $urandom();
      end
      a_out_ready = (c >= 300) || ($urandom_range(0, 1) == 1);
      #1;
      acc  = a_in_valid & a_in_ready;
      emit = a_out_valid & a_out_ready;
      if (emit) begin
        checks++;
        e = (q.size() != 0) ? q.pop_front() : ~a_out_data;
        if (a_out_data !== e) begin
          failures++;
          $display("FAIL d1_order: cycle %0d got %h, required %h", c, a_out_data, e);
        end
      end
      if (acc) q.push_back(a_in_data);
      pend = a_in_valid & ~acc;
      @(posedge clk);
      #1;
      checks++;
      if (int'(a_occupancy) !== q.size()) begin
        failures++;
        $display("FAIL d1_occupancy: cycle %0d got %0d, required %0d", c, a_occupancy, q.size());
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL d1_lossless: got %0d words undelivered, required 0", q.size());
    end
  endtask

  task automatic test_sweep_d7();
    logic [0:0] q[$];
    logic [0:0] e;
    logic       acc, emit, pend;
    pend = 1'b0;
    for (int c = 0; c < 340; c++) begin
      if (!pend) begin
        b_in_valid = (c < 300) && ($urandom_range(0, 1) == 1);
        b_in_data  = 1'($urandom_range(0, 1));
      end
      b_out_ready = (c >= 300) || ($urandom_range(0, 1) == 1);
      #1;
      acc  = b_in_valid & b_in_ready;
      emit = b_out_valid & b_out_ready;
      if (emit) begin
        checks++;
        e = (q.size() != 0) ? q.pop_front() : ~b_out_data;
        if (b_out_data !== e) begin
          failures++;
          $display("FAIL d7_order: cycle %0d got %b, required %b", c, b_out_data, e);
        end
      end
      if (acc) q.push_back(b_in_data);
      pend = b_in_valid & ~acc;
      @(posedge clk);
      #1;
      checks++;
      if (int'(b_occupancy) !== q.size()) begin
        failures++;
        $display("FAIL d7_occupancy: cycle %0d got %0d, required %0d", c, b_occupancy, q.size());
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL d7_lossless: got %0d words undelivered, required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_sweep_d1();
    test_sweep_d7();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
